// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program-counter register and instruction-fetch sequencer.
//            Takes the resolved next-PC from the branch logic, fetches the
//            word at that address from instruction memory and holds it for
//            decode under a valid/ack (instr_valid / pc_load) handshake.
//            Misaligned next-PC values and fetch timeouts raise a sticky
//            fault and halt the unit until reset.
// Options  : FETCH_PREFETCH_EN - when defined, adds a one-entry sequential
//            prefetch buffer that fetches pc_out+4 while decode holds the
//            current instruction, so a fall-through pc_load skips FETCH.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_next,
   input  logic        pc_load,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic        fault
);

   // Wait counter must be able to hold the value TIMEOUT itself.
   localparam int unsigned c_CNT_W       = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

`ifdef FETCH_PREFETCH_EN
   typedef enum logic [2:0] {
      ST_BOOT     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_HOLD     = 3'd2,
      ST_HALT     = 3'd3,
      ST_PREFETCH = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_BOOT     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_HOLD     = 3'd2,
      ST_HALT     = 3'd3
   } state_t;
`endif

   state_t               r_state;
   logic [31:0]          r_pc;
   logic [31:0]          r_instr;
   logic                 r_instr_valid;
   logic                 r_imem_req;
   logic [31:0]          r_imem_addr;
   logic                 r_fault;
   logic [c_CNT_W-1:0]   r_wait_cnt;

`ifdef FETCH_PREFETCH_EN
   logic [31:0]          r_pf_addr;
   logic [31:0]          r_pf_data;
   logic                 r_pf_valid;
`endif

   logic [c_CNT_W-1:0]   w_cnt_inc;
   logic                 w_timeout;
   logic                 w_misaligned;
`ifdef FETCH_PREFETCH_EN
   logic [31:0]          w_pc_seq;
   logic [31:0]          w_next_seq;
   logic                 w_pf_hit;
`endif

   // Timeout fires on the cycle the wait count would reach TIMEOUT; a
   // response arriving in that same cycle takes priority over the fault.
   assign w_cnt_inc    = r_wait_cnt + c_CNT_ONE;
   assign w_timeout    = (w_cnt_inc == c_TIMEOUT_CNT);
   assign w_misaligned = |pc_next[1:0];

`ifdef FETCH_PREFETCH_EN
   // Sequential addresses wrap naturally at 32 bits.
   assign w_pc_seq   = r_pc + 32'd4;
   assign w_next_seq = pc_next + 32'd4;
   // Buffer hit: the buffered word is exactly the one decode asks for next.
   assign w_pf_hit   = r_pf_valid && (pc_next == r_pf_addr);
`endif

   // Fetch sequencer: state, PC, instruction register and memory request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_BOOT;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_imem_req    <= 1'b0;
         r_imem_addr   <= RESET_PC;
         r_fault       <= 1'b0;
         r_wait_cnt    <= '0;
`ifdef FETCH_PREFETCH_EN
         r_pf_addr     <= '0;
         r_pf_data     <= '0;
         r_pf_valid    <= 1'b0;
`endif
      end else begin
         case (r_state)
            // One idle cycle after reset release before the first fetch.
            ST_BOOT: begin
               r_state     <= ST_FETCH;
               r_imem_req  <= 1'b1;
               r_imem_addr <= r_pc;
               r_wait_cnt  <= '0;
            end

            // Waiting for the demand fetch of pc_out.
            ST_FETCH: begin
               if (imem_ready) begin
                  r_instr       <= imem_rdata;
                  r_instr_valid <= 1'b1;
                  r_wait_cnt    <= '0;
`ifdef FETCH_PREFETCH_EN
                  // Immediately start fetching the fall-through word.
                  r_state       <= ST_PREFETCH;
                  r_imem_req    <= 1'b1;
                  r_imem_addr   <= w_pc_seq;
                  r_pf_addr     <= w_pc_seq;
                  r_pf_valid    <= 1'b0;
`else
                  r_state       <= ST_HOLD;
                  r_imem_req    <= 1'b0;
`endif
               end else if (w_timeout) begin
                  r_fault       <= 1'b1;
                  r_instr_valid <= 1'b0;
                  r_imem_req    <= 1'b0;
                  r_state       <= ST_HALT;
               end else begin
                  r_wait_cnt    <= w_cnt_inc;
               end
            end

            // Instruction presented to decode; pc_load retires it.
`ifdef FETCH_PREFETCH_EN
            ST_HOLD, ST_PREFETCH: begin
`else
            ST_HOLD: begin
`endif
               if (pc_load) begin
                  if (w_misaligned) begin
                     // PC is left pointing at the last good instruction.
                     r_fault       <= 1'b1;
                     r_instr_valid <= 1'b0;
                     r_imem_req    <= 1'b0;
                     r_state       <= ST_HALT;
`ifdef FETCH_PREFETCH_EN
                     r_pf_valid    <= 1'b0;
                  end else if (w_pf_hit) begin
                     // Serve from the buffer and chain the next prefetch.
                     r_instr       <= r_pf_data;
                     r_pc          <= pc_next;
                     r_pf_valid    <= 1'b0;
                     r_pf_addr     <= w_next_seq;
                     r_imem_req    <= 1'b1;
                     r_imem_addr   <= w_next_seq;
                     r_wait_cnt    <= '0;
                     r_state       <= ST_PREFETCH;
`endif
                  end else begin
                     // Redirect: any pending prefetch is abandoned.
                     r_pc          <= pc_next;
                     r_instr_valid <= 1'b0;
                     r_wait_cnt    <= '0;
                     r_imem_req    <= 1'b1;
                     r_imem_addr   <= pc_next;
                     r_state       <= ST_FETCH;
`ifdef FETCH_PREFETCH_EN
                     r_pf_valid    <= 1'b0;
`endif
                  end
`ifdef FETCH_PREFETCH_EN
               end else if (r_state == ST_PREFETCH) begin
                  if (imem_ready) begin
                     r_pf_data     <= imem_rdata;
                     r_pf_valid    <= 1'b1;
                     r_imem_req    <= 1'b0;
                     r_wait_cnt    <= '0;
                     r_state       <= ST_HOLD;
                  end else if (w_timeout) begin
                     // A lost prefetch is harmless; decode will demand-fetch.
                     r_pf_valid    <= 1'b0;
                     r_imem_req    <= 1'b0;
                     r_wait_cnt    <= '0;
                     r_state       <= ST_HOLD;
                  end else begin
                     r_wait_cnt    <= w_cnt_inc;
                  end
`endif
               end
            end

            // Absorbing fault state; only reset leaves it.
            ST_HALT: begin
               r_fault       <= 1'b1;
               r_instr_valid <= 1'b0;
               r_imem_req    <= 1'b0;
            end

            default: begin
               r_fault       <= 1'b1;
               r_instr_valid <= 1'b0;
               r_imem_req    <= 1'b0;
               r_state       <= ST_HALT;
            end
         endcase
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_imem_addr;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign pc_out      = r_pc;
   assign fault       = r_fault;

endmodule
`default_nettype wire
